// File: rtl/bus_snoop_ctrl.sv
// Snoop-based coherence controller: broadcasts one bus request to the other
// agents, merges their results, then issues the memory read, write or flush.
module bus_snoop_ctrl #(
   parameter int NUM_SNOOPERS  = 4,
   parameter int ADDR_W        = 32,
   parameter int SNOOP_TIMEOUT = 15,
   localparam int ID_W = (NUM_SNOOPERS > 1) ? $clog2(NUM_SNOOPERS) : 1
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [1:0]                req_op,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [ID_W-1:0]           req_id,
   output logic                      snp_valid,
   output logic [1:0]                snp_op,
   output logic [ADDR_W-1:0]         snp_addr,
   output logic [NUM_SNOOPERS-1:0]   snp_mask,
   input  logic [NUM_SNOOPERS-1:0]   snp_rsp_valid,
   input  logic [2*NUM_SNOOPERS-1:0] snp_rsp_res,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_wr,
   output logic [ADDR_W-1:0]         mem_req_addr,
   output logic                      done_valid,
   output logic [1:0]                done_res,
   output logic                      done_src,
   output logic                      done_err
);

   localparam int CNT_W = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SNOOP   = 3'd1;
   localparam logic [2:0] ST_COLLECT = 3'd2;
   localparam logic [2:0] ST_MEM     = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_INV   = 2'b11;

   localparam logic [1:0] RES_NOHIT = 2'b00;
   localparam logic [1:0] RES_HIT   = 2'b01;
   localparam logic [1:0] RES_HITM  = 2'b10;

   logic [2:0]                         state;
   logic                               ready_q;
   logic [1:0]                         op_q;
   logic [ADDR_W-1:0]                  addr_q;
   logic [NUM_SNOOPERS-1:0]            mask_q;
   logic [NUM_SNOOPERS-1:0]            got_q;
   logic [NUM_SNOOPERS-1:0][1:0]       res_q;
   logic [CNT_W-1:0]                   cnt_q;
   logic                               mem_wr_q;
   logic [1:0]                         done_res_q;
   logic                               done_src_q;
   logic                               done_err_q;

   logic [NUM_SNOOPERS-1:0]            mask_nxt;
   logic [NUM_SNOOPERS-1:0]            got_nxt;
   logic [NUM_SNOOPERS-1:0][1:0]       res_nxt;
   logic                               hitm_any;
   logic                               hitm_multi;
   logic                               hit_any;
   logic                               all_done;
   logic [1:0]                         comb_res;

   // NOTE: every combinational output gets a default before the loop so no latch is inferred.
   always_comb begin
      mask_nxt   = '0;
      got_nxt    = got_q;
      res_nxt    = res_q;
      hitm_any   = 1'b0;
      hitm_multi = 1'b0;
      hit_any    = 1'b0;
      for (int i = 0; i < NUM_SNOOPERS; i++) begin
         mask_nxt[i] = (ID_W'(i) != req_id);
         // Only the first strobe of a masked agent is taken; reserved code reads as NOHIT.
         if (snp_rsp_valid[i] && mask_q[i] && !got_q[i]) begin
            got_nxt[i] = 1'b1;
            res_nxt[i] = (snp_rsp_res[2*i +: 2] == 2'b11) ? RES_NOHIT : snp_rsp_res[2*i +: 2];
         end
         if (res_nxt[i] == RES_HITM) begin
            hitm_multi = hitm_multi | hitm_any;
            hitm_any   = 1'b1;
         end
         if (res_nxt[i] == RES_HIT) begin
            hit_any = 1'b1;
         end
      end
      all_done = &(got_nxt | ~mask_q);
      comb_res = hitm_any ? RES_HITM : (hit_any ? RES_HIT : RES_NOHIT);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rstb) begin
         state      <= ST_IDLE;
         ready_q    <= 1'b0;
         op_q       <= '0;
         addr_q     <= '0;
         mask_q     <= '0;
         got_q      <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
         mem_wr_q   <= 1'b0;
         done_res_q <= '0;
         done_src_q <= 1'b0;
         done_err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (req_valid && ready_q) begin
                  op_q    <= req_op;
                  addr_q  <= req_addr;
                  mask_q  <= mask_nxt;
                  got_q   <= '0;
                  res_q   <= '0;
                  ready_q <= 1'b0;
                  state   <= ST_SNOOP;
               end
            end
            ST_SNOOP: begin
               cnt_q <= '0;
               state <= ST_COLLECT;
            end
            ST_COLLECT: begin
               got_q <= got_nxt;
               res_q <= res_nxt;
               // Completion wins over timeout when the last answer lands on the final cycle.
               if (all_done || cnt_q == CNT_W'(SNOOP_TIMEOUT - 1)) begin
                  done_res_q <= comb_res;
                  done_err_q <= hitm_multi | ~all_done;
                  if (op_q == OP_INV) begin
                     mem_wr_q   <= 1'b0;
                     done_src_q <= 1'b0;
                     state      <= ST_DONE;
                  end else if (op_q == OP_WRITE) begin
                     mem_wr_q   <= 1'b1;
                     done_src_q <= 1'b0;
                     state      <= ST_MEM;
                  end else begin
                     mem_wr_q   <= hitm_any;
                     done_src_q <= hitm_any;
                     state      <= ST_MEM;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_MEM: begin
               if (mem_req_ready) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready     = ready_q;
   assign snp_valid     = (state == ST_SNOOP);
   assign snp_op        = op_q;
   assign snp_addr      = addr_q;
   assign snp_mask      = mask_q;
   assign mem_req_valid = (state == ST_MEM);
   assign mem_req_wr    = mem_wr_q;
   assign mem_req_addr  = addr_q;
   assign done_valid    = (state == ST_DONE);
   assign done_res      = done_res_q;
   assign done_src      = done_src_q;
   assign done_err      = done_err_q;

endmodule

// File: tb/tb_bus_snoop_ctrl.sv
// Self-checking bench for bus_snoop_ctrl: directed scenarios plus random
// transactions checked against a cycle-count model of the snoop protocol.
module tb_bus_snoop_ctrl;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int TMO = 15;

   logic          clk;
   logic          rstb;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [AW-1:0] req_addr;
   logic [1:0]    req_id;
   logic          snp_valid;
   logic [1:0]    snp_op;
   logic [AW-1:0] snp_addr;
   logic [N-1:0]  snp_mask;
   logic [N-1:0]  snp_rsp_valid;
   logic [2*N-1:0] snp_rsp_res;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_wr;
   logic [AW-1:0] mem_req_addr;
   logic          done_valid;
   logic [1:0]    done_res;
   logic          done_src;
   logic          done_err;

   int errors = 0;
   int checks = 0;

   // Per-agent answer plan: collect-relative cycle of first strobe (-1 = never) and result.
   int         plan_cyc [N];
   logic [1:0] plan_res [N];

   bus_snoop_ctrl #(.NUM_SNOOPERS(N), .ADDR_W(AW), .SNOOP_TIMEOUT(TMO)) dut (
      .clk(clk), .rstb(rstb),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_id(req_id),
      .snp_valid(snp_valid), .snp_op(snp_op), .snp_addr(snp_addr), .snp_mask(snp_mask),
      .snp_rsp_valid(snp_rsp_valid), .snp_rsp_res(snp_rsp_res),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
      .done_valid(done_valid), .done_res(done_res), .done_src(done_src), .done_err(done_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One full transaction; expectations come from the protocol rules, not the DUT.
   task automatic do_txn(input logic [1:0] op, input logic [1:0] id, input logic [AW-1:0] addr,
                         input bit dup, input int mdly, input string name);
      int all_k, exit_k, nh, mem_start, done_c, w, k;
      bit tmo, hit, emem, ewr, esrc, eerr, exp_mv;
      logic [1:0] eres;
      logic [N-1:0] emask, v;
      logic [2*N-1:0] r;

      all_k = 0;
      for (int i = 0; i < N; i++) begin
         if (i != int'(id)) begin
            if (plan_cyc[i] < 0) all_k = 1000;
            else if (plan_cyc[i] > all_k) all_k = plan_cyc[i];
         end
      end
      tmo    = (all_k > TMO - 1);
      exit_k = tmo ? TMO - 1 : all_k;
      nh  = 0;
      hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i != int'(id) && plan_cyc[i] >= 0 && plan_cyc[i] <= exit_k) begin
            if (plan_res[i] == 2'b10) nh++;
            if (plan_res[i] == 2'b01) hit = 1'b1;
         end
      end
      eres      = (nh > 0) ? 2'b10 : (hit ? 2'b01 : 2'b00);
      eerr      = tmo || (nh > 1);
      emem      = (op != 2'b11);
      ewr       = (op == 2'b01) || (emem && nh > 0);
      esrc      = (op == 2'b00 || op == 2'b10) && nh > 0;
      mem_start = 3 + exit_k;
      done_c    = emem ? mem_start + mdly + 1 : mem_start;
      emask     = 4'hF & ~(4'h1 << id);

      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s req_ready_wait got=%b exp=1", name, req_ready);
         return;
      end
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_id    = id;

      for (int c = 1; c <= done_c + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = 1'b0;
            req_op    = 2'($urandom);
            req_addr  = $urandom;
            req_id    = 2'($urandom);
         end
         checks++;
         if (snp_valid !== 1'(c == 1)) begin
            errors++;
            $display("FAIL %s snp_valid c=%0d got=%b exp=%b", name, c, snp_valid, c == 1);
         end
         if (c == 1) begin
            checks++;
            if (snp_mask !== emask || snp_op !== op || snp_addr !== addr) begin
               errors++;
               $display("FAIL %s snoop_fields got=%h/%h/%h exp=%h/%h/%h",
                        name, snp_mask, snp_op, snp_addr, emask, op, addr);
            end
         end
         checks++;
         if (done_valid !== 1'(c == done_c)) begin
            errors++;
            $display("FAIL %s done_valid c=%0d got=%b exp=%b (done at %0d)", name, c, done_valid, c == done_c, done_c);
         end
         exp_mv = emem && c >= mem_start && c < done_c;
         checks++;
         if (mem_req_valid !== exp_mv) begin
            errors++;
            $display("FAIL %s mem_req_valid c=%0d got=%b exp=%b", name, c, mem_req_valid, exp_mv);
         end
         if (exp_mv) begin
            checks++;
            if (mem_req_wr !== ewr || mem_req_addr !== addr) begin
               errors++;
               $display("FAIL %s mem_fields c=%0d got=%b/%h exp=%b/%h", name, c, mem_req_wr, mem_req_addr, ewr, addr);
            end
         end
         if (c == done_c) begin
            checks++;
            if (done_res !== eres || done_src !== esrc || done_err !== eerr) begin
               errors++;
               $display("FAIL %s done_fields got res=%b src=%b err=%b exp res=%b src=%b err=%b",
                        name, done_res, done_src, done_err, eres, esrc, eerr);
            end
         end
         if (c == done_c + 1) begin
            checks++;
            if (req_ready !== 1'b1) begin
               errors++;
               $display("FAIL %s req_ready_after_done got=%b exp=1", name, req_ready);
            end
         end
         k = c - 2;
         v = '0;
         r = 8'($urandom);
         for (int i = 0; i < N; i++) begin
            if (plan_cyc[i] >= 0 && k == plan_cyc[i]) begin
               v[i]       = 1'b1;
               r[2*i +: 2] = plan_res[i];
            end else if (dup && plan_cyc[i] >= 0 && k == plan_cyc[i] + 1) begin
               v[i]       = 1'b1;
               r[2*i +: 2] = 2'b10;
            end
         end
         snp_rsp_valid = v;
         snp_rsp_res   = r;
         mem_req_ready = (c >= mem_start + mdly) && (c < done_c);
      end
      snp_rsp_valid = '0;
      mem_req_ready = 1'b0;
   endtask

   task automatic test_reset;
      rstb = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, snp_valid, snp_op, snp_addr, snp_mask, mem_req_valid, mem_req_wr,
           mem_req_addr, done_valid, done_res, done_src, done_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ready=%b snp=%b mask=%h mem=%b done=%b exp all zero",
                  req_ready, snp_valid, snp_mask, mem_req_valid, done_valid);
      end
      rstb = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got=%b exp=1", req_ready);
      end
   endtask

   task automatic test_read_nohit;
      plan_cyc = '{-1, 0, 0, 0};
      plan_res = '{2'b00, 2'b00, 2'b00, 2'b00};
      do_txn(2'b00, 2'd0, 32'h100, 1'b0, 0, "read_nohit");
   endtask

   task automatic test_rwim_hitm;
      plan_cyc = '{0, 1, -1, 2};
      plan_res = '{2'b01, 2'b10, 2'b00, 2'b01};
      do_txn(2'b10, 2'd2, 32'h2240, 1'b0, 0, "rwim_hitm");
   endtask

   task automatic test_timeout;
      plan_cyc = '{3, -1, -1, -1};
      plan_res = '{2'b01, 2'b10, 2'b10, 2'b10};
      do_txn(2'b00, 2'd1, 32'h3300, 1'b0, 1, "timeout");
   endtask

   task automatic test_invalidate_dup;
      plan_cyc = '{0, 1, 2, 0};
      plan_res = '{2'b01, 2'b01, 2'b01, 2'b10};
      do_txn(2'b11, 2'd3, 32'h4400, 1'b1, 0, "inval_dup");
   endtask

   task automatic test_write_stall;
      plan_cyc = '{0, -1, 1, 0};
      plan_res = '{2'b00, 2'b00, 2'b11, 2'b01};
      do_txn(2'b01, 2'd1, 32'h5500, 1'b0, 5, "write_stall");
   endtask

   task automatic test_multi_hitm;
      plan_cyc = '{-1, 0, 1, 0};
      plan_res = '{2'b00, 2'b10, 2'b10, 2'b01};
      do_txn(2'b00, 2'd0, 32'h6600, 1'b0, 0, "multi_hitm");
   endtask

   task automatic test_reset_in_mem;
      int w;
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_addr  = 32'h7700;
      req_id    = 2'd0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      snp_rsp_valid = 4'b1110;
      snp_rsp_res   = '0;
      @(negedge clk);
      snp_rsp_valid = '0;
      checks++;
      if (mem_req_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mem_entry mem_req_valid got=%b exp=1", mem_req_valid);
      end
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b0 || done_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mem_drop got mem=%b done=%b exp 0/0", mem_req_valid, done_valid);
      end
      rstb = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (done_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mem_no_done c=%0d got=%b exp=0", c, done_valid);
         end
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mem_ready got=%b exp=1", req_ready);
      end
   endtask

   task automatic test_back_to_back;
      plan_cyc = '{0, 0, 0, 0};
      plan_res = '{2'b01, 2'b00, 2'b00, 2'b00};
      do_txn(2'b00, 2'd3, 32'h8800, 1'b0, 0, "b2b_first");
      plan_res = '{2'b00, 2'b10, 2'b00, 2'b00};
      do_txn(2'b10, 2'd0, 32'h8840, 1'b0, 0, "b2b_second");
   endtask

   task automatic test_random;
      int r;
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < N; i++) begin
            r = $urandom % 8;
            plan_cyc[i] = (r == 0) ? -1 : int'($urandom_range(0, (r == 1) ? 18 : 6));
            plan_res[i] = 2'($urandom);
         end
         do_txn(2'($urandom), 2'($urandom), $urandom, 1'($urandom), int'($urandom % 4), "random");
      end
   endtask

   initial begin
      rstb          = 1'b1;
      req_valid     = 1'b0;
      req_op        = '0;
      req_addr      = '0;
      req_id        = '0;
      snp_rsp_valid = '0;
      snp_rsp_res   = '0;
      mem_req_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_read_nohit();
      test_rwim_hitm();
      test_timeout();
      test_invalidate_dup();
      test_write_stall();
      test_multi_hitm();
      test_reset_in_mem();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
